mem_stage: RTL

Memory stage of the pipelined ARM core. It holds the EX/MEM and MEM/WB pipeline registers and consumes the Exec stage outputs (control bits, destination register, ALU result, store data). It runs load/store accesses over a req/ack data-memory port with wait states and a timeout, and stalls the upstream pipeline while an access is outstanding. It drives the writeback-stage signals and returns ALUResultM to Exec for forwarding.

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory stage of the pipelined ARM core: EX/MEM and MEM/WB registers plus a
// req/ack data-memory port with wait states, upstream stall and access timeout.
module mem_stage #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [3:0]  RdE,
   input  logic [31:0] ALUResultE,
   input  logic [31:0] WriteDataE,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        StallM,
   output logic [31:0] ALUResultM,
   output logic [3:0]  RdM,
   output logic        RegWriteM,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic [3:0]  RdW,
   output logic [31:0] ALUOutW,
   output logic [31:0] ReadDataW,
   output logic        mem_err
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [7:0]  cnt_r;
   logic [7:0]  cnt_nxt_s;
   logic        memtoreg_m_r;
   logic        memwrite_m_r;
   logic [31:0] writedata_m_r;
   logic        busy_s;
   logic        timeout_s;
   logic        ack_s;
   logic        stall_s;
   logic        memop_e_s;

   // A flushed slot never starts a memory access.
   assign memop_e_s = ~flush & (MemtoRegE | MemWriteE);

   // Access FSM state and wait counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= 8'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next state: every EX/MEM load restarts the FSM from the incoming op.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            cnt_nxt_s   = 8'd0;
            state_nxt_s = memop_e_s ? BUSY : IDLE;
         end
         BUSY: begin
            if (stall_s) begin
               cnt_nxt_s   = cnt_r + 8'd1;
               state_nxt_s = BUSY;
            end else begin
               cnt_nxt_s   = 8'd0;
               state_nxt_s = memop_e_s ? BUSY : IDLE;
            end
         end
         default: begin
            cnt_nxt_s   = 8'd0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // FSM outputs; ack beats timeout when both land in the same cycle.
   always_comb begin
      busy_s    = (state_r == BUSY);
      timeout_s = busy_s & (cnt_r == CNT_LAST);
      ack_s     = busy_s & mem_ack;
      stall_s   = busy_s & ~mem_ack & ~timeout_s;
      mem_req   = busy_s;
      mem_we    = busy_s & memwrite_m_r;
   end

   assign StallM    = stall_s;
   assign mem_addr  = {ALUResultM[31:2], 2'b00};
   assign mem_wdata = writedata_m_r;

   // EX/MEM pipeline register, frozen while the access is outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWriteM     <= 1'b0;
         memtoreg_m_r  <= 1'b0;
         memwrite_m_r  <= 1'b0;
         RdM           <= 4'd0;
         ALUResultM    <= 32'd0;
         writedata_m_r <= 32'd0;
      end else if (!stall_s) begin
         if (flush) begin
            RegWriteM     <= 1'b0;
            memtoreg_m_r  <= 1'b0;
            memwrite_m_r  <= 1'b0;
            RdM           <= 4'd0;
            ALUResultM    <= 32'd0;
            writedata_m_r <= 32'd0;
         end else begin
            RegWriteM     <= RegWriteE;
            memtoreg_m_r  <= MemtoRegE;
            memwrite_m_r  <= MemWriteE;
            RdM           <= RdE;
            ALUResultM    <= ALUResultE;
            writedata_m_r <= WriteDataE;
         end
      end
   end

   // MEM/WB pipeline register and sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         RdW       <= 4'd0;
         ALUOutW   <= 32'd0;
         ReadDataW <= 32'd0;
         mem_err   <= 1'b0;
      end else if (stall_s) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         RdW       <= 4'd0;
         ALUOutW   <= 32'd0;
         ReadDataW <= 32'd0;
      end else if (ack_s) begin
         RegWriteW <= RegWriteM;
         MemtoRegW <= memtoreg_m_r;
         RdW       <= RdM;
         ALUOutW   <= ALUResultM;
         ReadDataW <= mem_rdata;
      end else if (timeout_s) begin
         // Abandoned access retires without touching the register file.
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         RdW       <= RdM;
         ALUOutW   <= ALUResultM;
         ReadDataW <= 32'd0;
         mem_err   <= 1'b1;
      end else begin
         RegWriteW <= RegWriteM;
         MemtoRegW <= memtoreg_m_r;
         RdW       <= RdM;
         ALUOutW   <= ALUResultM;
         ReadDataW <= 32'd0;
      end
   end

endmodule
